uart_rx_os: RTL and testbench
=============================

Name: uart_rx_os

Overview:
- Parametrised oversampling UART receiver; successor of the fixed 8N1 receiver in the board I/O path.
- Adds runtime baud divider, configurable data width, optional parity, 1 or 2 stop bits, and a valid/ready output handshake.
- Adds parity, framing and overrun error reporting.
- Sits between the board RX pin and the command/FIFO logic.

Parameters:
- DATA_BITS, 8, data bits per frame, 5..9, LSB first.
- OVERSAMPLE, 16, ticks per bit period, even, >= 8.
- DIV_W, 16, width of baud_div_i.
- PARITY_EN, 0, 1 = parity bit follows the data bits.
- PARITY_ODD, 0, 1 = odd parity, 0 = even parity; ignored when PARITY_EN = 0.
- STOP_BITS, 1, number of stop bits, 1 or 2.

Ports:
- sysclk  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- baud_div_i  in  DIV_W  tick period minus 1; tick every baud_div_i+1 sysclk cycles.
- rx_i  in  1  asynchronous serial line, idle high.
- rx_data_o  out  DATA_BITS  received word.
- rx_valid_o  out  1  word and flags valid; held until accepted.
- rx_ready_i  in  1  consumer accepts the word when rx_valid_o & rx_ready_i.
- parity_err_o  out  1  parity mismatch on the held word; qualified by rx_valid_o.
- frame_err_o  out  1  a stop bit was sampled 0 on the held word; qualified by rx_valid_o.
- overrun_o  out  1  one-cycle pulse: a frame completed while rx_valid_o was high.
- busy_o  out  1  high in any state other than IDLE.

Behaviour:
- Reset (reset_n = 0 at a sysclk edge), all of the following from that edge:
  - State goes to IDLE; tick and bit counters clear.
  - Synchroniser flops are set to 1.
  - rx_data_o = 0; rx_valid_o, parity_err_o, frame_err_o, overrun_o and busy_o = 0.
  - Reset mid-frame discards the partial frame.
- Input: rx_i passes through a 2-FF synchroniser (rx_s). All decisions use rx_s.
- Tick generator:
  - Free-running counter 0..baud_div_i; tick is asserted for one cycle when count == baud_div_i.
  - baud_div_i = 0 gives a tick every cycle.
  - A change of baud_div_i takes effect at the next counter wrap.
  - The counter restarts at 0 when a start edge is detected, so sampling is phase-aligned to the edge.
- Sampling:
  - Each bit is decided by a 3-sample majority vote at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 within the bit period (tick index 0..OVERSAMPLE-1).
  - The bit value is 1 when at least 2 of the 3 samples are 1.
- State machine:
  - IDLE: arms only after rx_s has been 1 for at least one tick. A 1->0 transition on rx_s while armed -> START.
  - START: vote at mid-bit. Vote 1 = false start -> IDLE, no flags, no output. Vote 0 -> DATA at the end of the bit period.
  - DATA: DATA_BITS bit periods, shifted in LSB first. Then -> PARITY if PARITY_EN, else -> STOP.
  - PARITY: one bit period. Error when the XOR of the data bits and the parity bit is not equal to PARITY_ODD. -> STOP.
  - STOP: STOP_BITS bit periods. A 0 vote on any stop bit sets the frame error. After the centre vote of the last stop bit, go to IDLE immediately; do not wait for the end of the bit.
- Completion (the cycle after the last stop-bit vote):
  - If rx_valid_o = 0: load rx_data_o, parity_err_o and frame_err_o, and set rx_valid_o.
  - If rx_valid_o = 1 and rx_ready_i = 0: drop the new frame, keep the held word and flags, pulse overrun_o for 1 cycle.
  - If rx_valid_o = 1 and rx_ready_i = 1 in the same cycle: the old word is consumed, the new word is loaded, rx_valid_o stays 1, no overrun.
- Handshake:
  - rx_valid_o & rx_ready_i with no new completion in that cycle -> rx_valid_o = 0 on the next cycle.
  - Error flags clear together with rx_valid_o.
  - rx_ready_i is ignored while rx_valid_o = 0.
- Break (line held at 0):
  - The frame completes with frame_err_o = 1 and rx_data_o = 0.
  - No new start is detected until the line returns high for at least one tick.
- Latency: rx_valid_o rises 1 sysclk after the tick that carries the last stop-bit vote.

Test Plan:
- Default parameters (8N1, OVERSAMPLE = 16), baud_div_i = 4 (80 cycles per bit); send 0xA5, rx_ready_i held 1 -> rx_data_o = 0xA5, rx_valid_o high for 1 cycle, no error flags, busy_o low afterwards.
- PARITY_EN = 1, PARITY_ODD = 0; send 0x07 with parity bit 1 -> no parity error. Same byte with parity bit 0 -> parity_err_o = 1 together with rx_valid_o.
- Stop bit driven 0 for byte 0x3C -> rx_data_o = 0x3C, frame_err_o = 1. Line held 0 for 20 bit periods -> exactly one frame with rx_data_o = 0x00 and frame_err_o = 1, then no further frames until the line goes high.
- rx_ready_i = 0; send 0x11 then 0x22 -> rx_data_o stays 0x11, overrun_o pulses once. Then rx_ready_i = 1 for one cycle -> rx_valid_o drops.
- Glitches: a 0 pulse of 3 ticks on an idle line -> false start, no rx_valid_o, busy_o high then low. A single-tick glitch at a mid-bit sample of a data bit in 0x55 -> majority vote still yields 0x55.
- Reset asserted mid-data of 0xF0, released, then 0x0F sent -> only 0x0F delivered, all outputs 0 while reset is held.

Source files
------------

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: 2-FF input synchroniser, runtime baud tick, 3-sample
// majority vote per bit, optional parity, 1/2 stop bits and a valid/ready output.
module uart_rx_os #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16,
  parameter bit PARITY_EN  = 1'b0,
  parameter bit PARITY_ODD = 1'b0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 sysclk,
  input  logic                 reset_n,
  input  logic [DIV_W-1:0]     baud_div_i,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 rx_valid_o,
  input  logic                 rx_ready_i,
  output logic                 parity_err_o,
  output logic                 frame_err_o,
  output logic                 overrun_o,
  output logic                 busy_o
);

  localparam int OS_W  = $clog2(OVERSAMPLE);
  localparam int BIT_W = 4;
  localparam logic [OS_W-1:0]  SAMP_A    = OS_W'(OVERSAMPLE/2 - 1);
  localparam logic [OS_W-1:0]  SAMP_B    = OS_W'(OVERSAMPLE/2);
  localparam logic [OS_W-1:0]  SAMP_C    = OS_W'(OVERSAMPLE/2 + 1);
  localparam logic [OS_W-1:0]  OS_LAST   = OS_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                r_state;
  state_t                w_state_nx;
  logic                  r_sync1;
  logic                  r_sync2;
  logic [DIV_W-1:0]      r_div_cnt;
  logic [DIV_W-1:0]      r_div_lat;
  logic [OS_W-1:0]       r_os_cnt;
  logic [BIT_W-1:0]      r_bit_cnt;
  logic                  r_armed;
  logic                  r_samp_a;
  logic                  r_samp_b;
  logic [DATA_BITS-1:0]  r_shift;
  logic                  r_par_bit;
  logic                  r_ferr;
  logic [DATA_BITS-1:0]  r_data;
  logic                  r_valid;
  logic                  r_perr_o;
  logic                  r_ferr_o;
  logic                  r_overrun;

  logic w_rx_s;
  logic w_tick;
  logic w_start;
  logic w_vote_tick;
  logic w_bit_end;
  logic w_vote;
  logic w_done;
  logic w_bit_clr;
  logic w_bit_inc;
  logic w_perr_fin;
  logic w_ferr_fin;

  assign w_rx_s      = r_sync2;
  assign w_tick      = (r_div_cnt == r_div_lat);
  assign w_start     = (r_state == S_IDLE) && r_armed && !w_rx_s;
  assign w_vote_tick = w_tick && (r_os_cnt == SAMP_C);
  assign w_bit_end   = w_tick && (r_os_cnt == OS_LAST);
  assign w_vote      = (r_samp_a & r_samp_b) | (r_samp_a & w_rx_s) | (r_samp_b & w_rx_s);
  assign w_done      = (r_state == S_STOP) && w_vote_tick && (r_bit_cnt == STOP_LAST);
  assign w_perr_fin  = PARITY_EN && (((^r_shift) ^ r_par_bit) != PARITY_ODD);
  assign w_ferr_fin  = r_ferr | ~w_vote;

  // Stage: input synchroniser and baud tick
  always_ff @(posedge sysclk) begin
    if (!reset_n) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_div_cnt <= '0;
      r_div_lat <= baud_div_i;
    end else begin
      r_sync1 <= rx_i;
      r_sync2 <= r_sync1;
      if (w_start || w_tick) begin
        r_div_cnt <= '0;
        r_div_lat <= baud_div_i;
      end else begin
        r_div_cnt <= r_div_cnt + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge sysclk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_bit_clr  = 1'b0;
    w_bit_inc  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_nx = S_START;
          w_bit_clr  = 1'b1;
        end
      end
      S_START: begin
        if (w_vote_tick && w_vote) begin
          w_state_nx = S_IDLE;
        end else if (w_bit_end) begin
          w_state_nx = S_DATA;
          w_bit_clr  = 1'b1;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          if (r_bit_cnt == DATA_LAST) begin
            w_state_nx = PARITY_EN ? S_PARITY : S_STOP;
            w_bit_clr  = 1'b1;
          end else begin
            w_bit_inc = 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (w_bit_end) begin
          w_state_nx = S_STOP;
          w_bit_clr  = 1'b1;
        end
      end
      S_STOP: begin
        if (w_done) begin
          w_state_nx = S_IDLE;
        end else if (w_bit_end) begin
          w_bit_inc = 1'b1;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Stage: bit timing, arming and sample capture
  always_ff @(posedge sysclk) begin
    if (!reset_n) begin
      r_os_cnt  <= '0;
      r_bit_cnt <= '0;
      r_armed   <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      if (w_start) begin
        r_os_cnt <= '0;
      end else if (w_tick && (r_state != S_IDLE)) begin
        if ((r_os_cnt == OS_LAST) || (w_state_nx == S_IDLE)) begin
          r_os_cnt <= '0;
        end else begin
          r_os_cnt <= r_os_cnt + OS_W'(1);
        end
      end

      if (w_bit_clr) begin
        r_bit_cnt <= '0;
      end else if (w_bit_inc) begin
        r_bit_cnt <= r_bit_cnt + BIT_W'(1);
      end

      // Re-arming needs a full tick of idle-high line, which also blocks restarts during a break.
      if ((r_state != S_IDLE) && (w_state_nx == S_IDLE)) begin
        r_armed <= 1'b0;
      end else if (r_state == S_IDLE) begin
        if (!w_rx_s) begin
          r_armed <= 1'b0;
        end else if (w_tick) begin
          r_armed <= 1'b1;
        end
      end

      if (w_start) begin
        r_ferr <= 1'b0;
      end else if ((r_state == S_STOP) && w_vote_tick && !w_vote) begin
        r_ferr <= 1'b1;
      end
    end
  end

  always_ff @(posedge sysclk) begin
    if (w_tick && (r_os_cnt == SAMP_A)) r_samp_a <= w_rx_s;
    if (w_tick && (r_os_cnt == SAMP_B)) r_samp_b <= w_rx_s;
    if ((r_state == S_DATA) && w_vote_tick) begin
      r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
    end
    if ((r_state == S_PARITY) && w_vote_tick) begin
      r_par_bit <= w_vote;
    end
  end

  // Stage: output holding register and handshake
  always_ff @(posedge sysclk) begin
    if (!reset_n) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_perr_o  <= 1'b0;
      r_ferr_o  <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= w_done && r_valid && !rx_ready_i;
      if (w_done && (!r_valid || rx_ready_i)) begin
        r_valid  <= 1'b1;
        r_data   <= r_shift;
        r_perr_o <= w_perr_fin;
        r_ferr_o <= w_ferr_fin;
      end else if (r_valid && rx_ready_i) begin
        r_valid  <= 1'b0;
        r_perr_o <= 1'b0;
        r_ferr_o <= 1'b0;
      end
    end
  end

  assign rx_data_o    = r_data;
  assign rx_valid_o   = r_valid;
  assign parity_err_o = r_perr_o;
  assign frame_err_o  = r_ferr_o;
  assign overrun_o    = r_overrun;
  assign busy_o       = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboard bench for uart_rx_os: an 8N1 instance and an 8E1 instance, baud_div_i = 4.
module tb_uart_rx_os;

  localparam int BITC = 80;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] baud = 16'd4;
  logic        rx_a = 1'b1;
  logic        rx_p = 1'b1;
  logic        ready_a = 1'b1;
  logic        ready_p = 1'b1;

  logic [7:0] a_data, p_data;
  logic a_valid, a_perr, a_ferr, a_ovr, a_busy;
  logic p_valid, p_perr, p_ferr, p_ovr, p_busy;

  exp_t q_a[$];
  exp_t q_p[$];
  int checks = 0;
  int errors = 0;
  int ovr_a = 0;
  int vcnt_a = 0;

  always #5 clk = ~clk;

  uart_rx_os #(.DATA_BITS(8), .OVERSAMPLE(16), .DIV_W(16), .PARITY_EN(1'b0),
               .PARITY_ODD(1'b0), .STOP_BITS(1)) u_a (
    .sysclk(clk), .reset_n(rst_n), .baud_div_i(baud), .rx_i(rx_a),
    .rx_data_o(a_data), .rx_valid_o(a_valid), .rx_ready_i(ready_a),
    .parity_err_o(a_perr), .frame_err_o(a_ferr), .overrun_o(a_ovr), .busy_o(a_busy));

  uart_rx_os #(.DATA_BITS(8), .OVERSAMPLE(16), .DIV_W(16), .PARITY_EN(1'b1),
               .PARITY_ODD(1'b0), .STOP_BITS(1)) u_p (
    .sysclk(clk), .reset_n(rst_n), .baud_div_i(baud), .rx_i(rx_p),
    .rx_data_o(p_data), .rx_valid_o(p_valid), .rx_ready_i(ready_p),
    .parity_err_o(p_perr), .frame_err_o(p_ferr), .overrun_o(p_ovr), .busy_o(p_busy));

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  function automatic exp_t mk(input logic [7:0] d, input logic pe, input logic fe);
    exp_t e;
    e.d  = d;
    e.pe = pe;
    e.fe = fe;
    return e;
  endfunction

  // Monitors: compare every accepted word against the head of its queue
  always @(negedge clk) begin
    if (rst_n && a_valid) vcnt_a++;
    if (rst_n && a_ovr) ovr_a++;
    if (rst_n && a_valid && ready_a) begin
      if (q_a.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_unexpected: got data=%0h, expected no word", a_data);
      end else begin
        exp_t e;
        e = q_a.pop_front();
        chk("a_data", 32'(a_data), 32'(e.d));
        chk("a_parity_err", 32'(a_perr), 32'(e.pe));
        chk("a_frame_err", 32'(a_ferr), 32'(e.fe));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && p_valid && ready_p) begin
      if (q_p.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL p_unexpected: got data=%0h, expected no word", p_data);
      end else begin
        exp_t e;
        e = q_p.pop_front();
        chk("p_data", 32'(p_data), 32'(e.d));
        chk("p_parity_err", 32'(p_perr), 32'(e.pe));
        chk("p_frame_err", 32'(p_ferr), 32'(e.fe));
      end
    end
  end

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_line(input bit which, input logic v);
    if (which) rx_p = v;
    else       rx_a = v;
  endtask

  task automatic drive_bit(input bit which, input logic v, input bit glitch);
    set_line(which, v);
    if (glitch) begin
      hold(42);
      set_line(which, ~v);
      hold(5);
      set_line(which, v);
      hold(BITC - 47);
    end else begin
      hold(BITC);
    end
  endtask

  task automatic send_frame(input bit which, input logic [7:0] d, input bit par_en,
                            input logic par, input logic stop, input int gbit);
    drive_bit(which, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(which, d[i], gbit == i);
    if (par_en) drive_bit(which, par, 1'b0);
    drive_bit(which, stop, 1'b0);
    set_line(which, 1'b1);
    hold(2 * BITC);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, 32'(a_valid), 0);
    chk({tag, "_data"}, 32'(a_data), 0);
    chk({tag, "_perr"}, 32'(a_perr), 0);
    chk({tag, "_ferr"}, 32'(a_ferr), 0);
    chk({tag, "_overrun"}, 32'(a_ovr), 0);
    chk({tag, "_busy"}, 32'(a_busy), 0);
  endtask

  initial begin
    int v0;
    int o0;
    hold(5);
    chk_reset_outputs("rst");
    chk("rst_p_valid", 32'(p_valid), 0);
    chk("rst_p_busy", 32'(p_busy), 0);
    rst_n = 1'b1;
    hold(40);

    v0 = vcnt_a;
    q_a.push_back(mk(8'hA5, 1'b0, 1'b0));
    send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, -1);
    chk("a5_busy_after", 32'(a_busy), 0);
    chk("a5_valid_cycles", 32'(vcnt_a - v0), 1);
    chk("a5_delivered", 32'(q_a.size()), 0);

    q_p.push_back(mk(8'h07, 1'b0, 1'b0));
    send_frame(1'b1, 8'h07, 1'b1, 1'b1, 1'b1, -1);
    q_p.push_back(mk(8'h07, 1'b1, 1'b0));
    send_frame(1'b1, 8'h07, 1'b1, 1'b0, 1'b1, -1);
    chk("parity_delivered", 32'(q_p.size()), 0);

    q_a.push_back(mk(8'h3C, 1'b0, 1'b1));
    send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, -1);
    chk("stop0_delivered", 32'(q_a.size()), 0);

    q_a.push_back(mk(8'h00, 1'b0, 1'b1));
    rx_a = 1'b0;
    hold(20 * BITC - 10);
    chk("break_idle_busy", 32'(a_busy), 0);
    hold(10);
    rx_a = 1'b1;
    hold(2 * BITC);
    chk("break_delivered", 32'(q_a.size()), 0);

    ready_a = 1'b0;
    o0 = ovr_a;
    q_a.push_back(mk(8'h11, 1'b0, 1'b0));
    send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1, -1);
    send_frame(1'b0, 8'h22, 1'b0, 1'b0, 1'b1, -1);
    chk("ovr_pulses", 32'(ovr_a - o0), 1);
    chk("ovr_valid_held", 32'(a_valid), 1);
    chk("ovr_data_held", 32'(a_data), 32'h11);
    ready_a = 1'b1;
    hold(1);
    ready_a = 1'b0;
    chk("ovr_valid_drop", 32'(a_valid), 0);
    chk("ovr_delivered", 32'(q_a.size()), 0);
    ready_a = 1'b1;

    v0 = vcnt_a;
    rx_a = 1'b0;
    hold(10);
    chk("false_start_busy_high", 32'(a_busy), 1);
    hold(5);
    rx_a = 1'b1;
    hold(100);
    chk("false_start_busy_low", 32'(a_busy), 0);
    chk("false_start_no_word", 32'(vcnt_a - v0), 0);

    q_a.push_back(mk(8'h55, 1'b0, 1'b0));
    send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b1, 2);
    chk("glitch_delivered", 32'(q_a.size()), 0);

    rx_a = 1'b0;
    hold(BITC);
    hold(3 * BITC);
    rst_n = 1'b0;
    rx_a = 1'b1;
    hold(10);
    chk_reset_outputs("midrst");
    rst_n = 1'b1;
    hold(40);
    q_a.push_back(mk(8'h0F, 1'b0, 1'b0));
    send_frame(1'b0, 8'h0F, 1'b0, 1'b0, 1'b1, -1);
    chk("after_reset_delivered", 32'(q_a.size()), 0);
    chk("p_queue_final", 32'(q_p.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
